// File: rtl/dest_ip_tbl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dest_ip_tbl_pkg
// Description : Shared register map, STATUS/CMD bit positions and FSM
//               encodings for the destination-IP table controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dest_ip_tbl_pkg;

    // Word offsets, decoded from address bits [4:2]
    localparam logic [2:0] c_REG_IDX    = 3'd0;
    localparam logic [2:0] c_REG_WDATA  = 3'd1;
    localparam logic [2:0] c_REG_CMD    = 3'd2;
    localparam logic [2:0] c_REG_RDATA  = 3'd3;
    localparam logic [2:0] c_REG_STATUS = 3'd4;

    localparam int c_STAT_BUSY = 0;
    localparam int c_STAT_DONE = 1;
    localparam int c_STAT_ERR  = 2;
    localparam int c_STAT_TMO  = 3;

    localparam int c_CMD_WR = 0;
    localparam int c_CMD_RD = 1;

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_ISSUE_WR = 3'd1;
    localparam logic [2:0] c_S_WAIT_WR  = 3'd2;
    localparam logic [2:0] c_S_ISSUE_RD = 3'd3;
    localparam logic [2:0] c_S_WAIT_RD  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/dest_ip_tbl_axil_if.sv
`default_nettype none
// ============================================================================
// Module      : dest_ip_tbl_axil_if
// Description : AXI4-Lite slave handshakes, IDX/WDATA registers, read mux and
//               command / W1C strobe decode for the table controller.
// Revision    : 1.0 - initial release
// ============================================================================
module dest_ip_tbl_axil_if
    import dest_ip_tbl_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int TAW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [AW-1:0]  i_awaddr,
    input  logic           i_awvalid,
    output logic           o_awready,
    input  logic [DW-1:0]  i_wdata,
    input  logic           i_wvalid,
    output logic           o_wready,
    output logic [1:0]     o_bresp,
    output logic           o_bvalid,
    input  logic           i_bready,
    input  logic [AW-1:0]  i_araddr,
    input  logic           i_arvalid,
    output logic           o_arready,
    output logic [DW-1:0]  o_rdata,
    output logic [1:0]     o_rresp,
    output logic           o_rvalid,
    input  logic           i_rready,
    input  logic [DW-1:0]  i_tbl_rdata,
    input  logic [3:0]     i_status,
    output logic [TAW-1:0] o_idx,
    output logic [DW-1:0]  o_wdata,
    output logic           o_cmd_wr,
    output logic           o_cmd_rd,
    output logic           o_cmd_bad,
    output logic           o_clr_done,
    output logic           o_clr_err,
    output logic           o_clr_tmo
);

    logic           r_en;
    logic           r_bvalid;
    logic           r_rvalid;
    logic [DW-1:0]  r_rdata;
    logic [TAW-1:0] r_idx;
    logic [DW-1:0]  r_wdata;
    logic           w_wr_fire;
    logic           w_rd_fire;
    logic [2:0]     w_wsel;
    logic           w_cmd_sel;
    logic           w_stat_sel;
    logic [DW-1:0]  w_rmux;
    logic           w_unused;

    // Readies stay low until the first clock after reset release
    assign w_wr_fire  = i_awvalid & i_wvalid & ~r_bvalid & r_en;
    assign w_rd_fire  = i_arvalid & ~r_rvalid & r_en;
    assign w_wsel     = i_awaddr[4:2];
    assign w_cmd_sel  = w_wr_fire & (w_wsel == c_REG_CMD);
    assign w_stat_sel = w_wr_fire & (w_wsel == c_REG_STATUS);

    assign o_awready = w_wr_fire;
    assign o_wready  = w_wr_fire;
    assign o_arready = w_rd_fire;
    assign o_bvalid  = r_bvalid;
    assign o_rvalid  = r_rvalid;
    assign o_rdata   = r_rdata;
    assign o_bresp   = 2'b00;
    assign o_rresp   = 2'b00;
    assign o_idx     = r_idx;
    assign o_wdata   = r_wdata;

    assign o_cmd_wr   = w_cmd_sel & i_wdata[c_CMD_WR] & ~i_wdata[c_CMD_RD];
    assign o_cmd_rd   = w_cmd_sel & i_wdata[c_CMD_RD] & ~i_wdata[c_CMD_WR];
    assign o_cmd_bad  = w_cmd_sel & ~(i_wdata[c_CMD_WR] ^ i_wdata[c_CMD_RD]);
    assign o_clr_done = w_stat_sel & i_wdata[c_STAT_DONE];
    assign o_clr_err  = w_stat_sel & i_wdata[c_STAT_ERR];
    assign o_clr_tmo  = w_stat_sel & i_wdata[c_STAT_TMO];

    assign w_unused = ^{i_awaddr[AW-1:5], i_awaddr[1:0], i_araddr[AW-1:5], i_araddr[1:0]};

    always_comb begin
        w_rmux = '0;
        case (i_araddr[4:2])
            c_REG_IDX:    w_rmux[TAW-1:0] = r_idx;
            c_REG_WDATA:  w_rmux = r_wdata;
            c_REG_RDATA:  w_rmux = i_tbl_rdata;
            c_REG_STATUS: w_rmux[3:0] = i_status;
            default:      w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_idx    <= '0;
            r_wdata  <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_wr_fire)
                r_bvalid <= 1'b1;
            else if (i_bready)
                r_bvalid <= 1'b0;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rmux;
            end else if (i_rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_wr_fire && w_wsel == c_REG_IDX)
                r_idx <= i_wdata[TAW-1:0];
            if (w_wr_fire && w_wsel == c_REG_WDATA)
                r_wdata <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dest_ip_tbl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dest_ip_tbl_ctrl
// Description : AXI4-Lite driven initiator for the destination-IP table port.
//               Optional ack timeout enabled by DEST_IP_TBL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dest_ip_tbl_ctrl
    import dest_ip_tbl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int TBL_ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            tbl_wr_req,
    output logic [TBL_ADDR_WIDTH-1:0]       tbl_wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
    output logic                            tbl_rd_req,
    output logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr,
    input  logic                            tbl_wr_ack,
    input  logic                            tbl_rd_ack,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int TAW = TBL_ADDR_WIDTH;

    logic [2:0]     r_state;
    logic [2:0]     w_state_nxt;
    logic [TAW-1:0] r_wr_addr;
    logic [TAW-1:0] r_rd_addr;
    logic [DW-1:0]  r_wr_data;
    logic [DW-1:0]  r_rdata;
    logic           r_done;
    logic           r_err;
    logic           r_tmo;
    logic [TAW-1:0] w_idx;
    logic [DW-1:0]  w_wdata;
    logic           w_cmd_wr;
    logic           w_cmd_rd;
    logic           w_cmd_bad;
    logic           w_clr_done;
    logic           w_clr_err;
    logic           w_clr_tmo;
    logic           w_busy;
    logic           w_waiting;
    logic           w_tmo_hit;
    logic           w_done_set;
    logic           w_rd_cap;
    logic           w_to_set;
    logic           w_err_set;
    logic [3:0]     w_status;
    logic           w_unused;

    dest_ip_tbl_axil_if #(
        .DW  (DW),
        .AW  (C_S_AXI_ADDR_WIDTH),
        .TAW (TAW)
    ) u_axil_if (
        .clk         (AXI_ACLK),
        .rst_n       (AXI_RESETN),
        .i_awaddr    (S_AXI_AWADDR),
        .i_awvalid   (S_AXI_AWVALID),
        .o_awready   (S_AXI_AWREADY),
        .i_wdata     (S_AXI_WDATA),
        .i_wvalid    (S_AXI_WVALID),
        .o_wready    (S_AXI_WREADY),
        .o_bresp     (S_AXI_BRESP),
        .o_bvalid    (S_AXI_BVALID),
        .i_bready    (S_AXI_BREADY),
        .i_araddr    (S_AXI_ARADDR),
        .i_arvalid   (S_AXI_ARVALID),
        .o_arready   (S_AXI_ARREADY),
        .o_rdata     (S_AXI_RDATA),
        .o_rresp     (S_AXI_RRESP),
        .o_rvalid    (S_AXI_RVALID),
        .i_rready    (S_AXI_RREADY),
        .i_tbl_rdata (r_rdata),
        .i_status    (w_status),
        .o_idx       (w_idx),
        .o_wdata     (w_wdata),
        .o_cmd_wr    (w_cmd_wr),
        .o_cmd_rd    (w_cmd_rd),
        .o_cmd_bad   (w_cmd_bad),
        .o_clr_done  (w_clr_done),
        .o_clr_err   (w_clr_err),
        .o_clr_tmo   (w_clr_tmo)
    );

    assign w_unused  = ^S_AXI_WSTRB;
    assign w_busy    = (r_state != c_S_IDLE);
    assign w_waiting = (r_state == c_S_WAIT_WR) || (r_state == c_S_WAIT_RD);
    assign w_status  = {r_tmo, r_err, r_done, w_busy};

    assign tbl_wr_req  = (r_state == c_S_ISSUE_WR);
    assign tbl_rd_req  = (r_state == c_S_ISSUE_RD);
    assign tbl_wr_addr = r_wr_addr;
    assign tbl_rd_addr = r_rd_addr;
    assign tbl_wr_data = r_wr_data;

`ifdef DEST_IP_TBL_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN)
            r_tmo_cnt <= '0;
        else if (tbl_wr_req || tbl_rd_req)
            r_tmo_cnt <= '0;
        else if (w_waiting)
            r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
    end

    // Fires on the TIMEOUT_CYCLES-th wait cycle without an ack
    assign w_tmo_hit = w_waiting && (r_tmo_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        w_rd_cap    = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_cmd_wr)
                    w_state_nxt = c_S_ISSUE_WR;
                else if (w_cmd_rd)
                    w_state_nxt = c_S_ISSUE_RD;
            end
            c_S_ISSUE_WR: w_state_nxt = c_S_WAIT_WR;
            c_S_ISSUE_RD: w_state_nxt = c_S_WAIT_RD;
            c_S_WAIT_WR: begin
                if (tbl_wr_ack) begin
                    w_state_nxt = c_S_IDLE;
                    w_done_set  = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_S_IDLE;
                    w_to_set    = 1'b1;
                end
            end
            c_S_WAIT_RD: begin
                if (tbl_rd_ack) begin
                    w_state_nxt = c_S_IDLE;
                    w_done_set  = 1'b1;
                    w_rd_cap    = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_S_IDLE;
                    w_to_set    = 1'b1;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Any command while busy is dropped; malformed commands never start
    assign w_err_set = w_cmd_bad | w_to_set | (w_busy & (w_cmd_wr | w_cmd_rd));

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            r_state   <= c_S_IDLE;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_wr_data <= '0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_busy && w_cmd_wr) begin
                r_wr_addr <= w_idx;
                r_wr_data <= w_wdata;
            end
            if (!w_busy && w_cmd_rd)
                r_rd_addr <= w_idx;
            if (w_rd_cap)
                r_rdata <= tbl_rd_data;
            // Set beats a simultaneous write-one-to-clear
            r_done <= w_done_set | (r_done & ~w_clr_done);
            r_err  <= w_err_set  | (r_err  & ~w_clr_err);
            r_tmo  <= w_to_set   | (r_tmo  & ~w_clr_tmo);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dest_ip_tbl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dest_ip_tbl_ctrl
// Description : Self-checking bench for dest_ip_tbl_ctrl with a table
//               responder and a register-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dest_ip_tbl_ctrl;

    localparam logic [31:0] A_IDX    = 32'h00;
    localparam logic [31:0] A_WDATA  = 32'h04;
    localparam logic [31:0] A_CMD    = 32'h08;
    localparam logic [31:0] A_RDATA  = 32'h0C;
    localparam logic [31:0] A_STATUS = 32'h10;

    logic        AXI_ACLK = 1'b0;
    logic        AXI_RESETN = 1'b0;
    logic [31:0] S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = 4'hF;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        tbl_wr_req;
    logic [4:0]  tbl_wr_addr;
    logic [31:0] tbl_wr_data;
    logic        tbl_rd_req;
    logic [4:0]  tbl_rd_addr;
    logic        tbl_wr_ack = 1'b0;
    logic        tbl_rd_ack = 1'b0;
    logic [31:0] tbl_rd_data = '0;

    int tests_run = 0;
    int tests_failed = 0;

    // Responder state
    logic [31:0] resp_mem [32] = '{default: 32'h0};
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    logic [4:0]  seen_wr_addr = '0;
    logic [31:0] seen_wr_data = '0;
    logic [4:0]  seen_rd_addr = '0;
    logic        wr_seen, rd_seen;
    bit          stall = 1'b0;
    bit          force_wr_ack = 1'b0;

    // Reference model
    logic [31:0] model_mem [32];
    logic [31:0] model_rdata;
    logic        hs_wr_req, hs_rd_req;

    always #5 AXI_ACLK = ~AXI_ACLK;

    dest_ip_tbl_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .TBL_ADDR_WIDTH     (5),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .AXI_ACLK      (AXI_ACLK),
        .AXI_RESETN    (AXI_RESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .tbl_wr_req    (tbl_wr_req),
        .tbl_wr_addr   (tbl_wr_addr),
        .tbl_wr_data   (tbl_wr_data),
        .tbl_rd_req    (tbl_rd_req),
        .tbl_rd_addr   (tbl_rd_addr),
        .tbl_wr_ack    (tbl_wr_ack),
        .tbl_rd_ack    (tbl_rd_ack),
        .tbl_rd_data   (tbl_rd_data)
    );

    // Table responder: acks one cycle after a request unless stalled
    always @(posedge AXI_ACLK) begin
        wr_seen = tbl_wr_req;
        rd_seen = tbl_rd_req;
        if (wr_seen) begin
            wr_pulses++;
            seen_wr_addr = tbl_wr_addr;
            seen_wr_data = tbl_wr_data;
            resp_mem[tbl_wr_addr] = tbl_wr_data;
        end
        if (rd_seen) begin
            rd_pulses++;
            seen_rd_addr = tbl_rd_addr;
        end
        #1;
        tbl_wr_ack  = (wr_seen && !stall) || force_wr_ack;
        tbl_rd_ack  = rd_seen && !stall;
        tbl_rd_data = tbl_rd_ack ? resp_mem[tbl_rd_addr] : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        n = 0;
        @(negedge AXI_ACLK);
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin
            n++;
            @(negedge AXI_ACLK);
        end
        if (n >= 20) check("aw_w_handshake", {31'b0, S_AXI_AWREADY}, 32'd1);
        @(posedge AXI_ACLK);
        #1;
        hs_wr_req     = tbl_wr_req;
        hs_rd_req     = tbl_rd_req;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            n++;
            @(negedge AXI_ACLK);
        end
        if (n >= 20) check("b_handshake", {31'b0, S_AXI_BVALID}, 32'd1);
        @(posedge AXI_ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        @(negedge AXI_ACLK);
        while (!S_AXI_ARREADY && n < 20) begin
            n++;
            @(negedge AXI_ACLK);
        end
        if (n >= 20) check("ar_handshake", {31'b0, S_AXI_ARREADY}, 32'd1);
        @(posedge AXI_ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            n++;
            @(negedge AXI_ACLK);
        end
        if (n >= 20) check("r_handshake", {31'b0, S_AXI_RVALID}, 32'd1);
        data = S_AXI_RDATA;
        @(posedge AXI_ACLK);
        #1;
        S_AXI_RREADY = 1'b0;
    endtask

    // Polls STATUS until BUSY clears (bounded) and returns the last value
    task automatic read_status_idle(output logic [31:0] st);
        int n;
        n = 0;
        axi_read(A_STATUS, st);
        while (st[0] && n < 20) begin
            n++;
            axi_read(A_STATUS, st);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] st;
        int          wp0, rp0;
        logic [4:0]  idx;
        logic [31:0] wd;
        int          op;

        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        model_rdata = 32'h0;

        // Reset values
        repeat (3) @(posedge AXI_ACLK);
        #1;
        check("rst_reqs", {30'b0, tbl_wr_req, tbl_rd_req}, 32'd0);
        check("rst_wr_data", tbl_wr_data, 32'd0);
        check("rst_valids", {29'b0, S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY}, 32'd0);
        check("rst_rdata_bus", S_AXI_RDATA, 32'd0);
        @(negedge AXI_ACLK);
        AXI_RESETN = 1'b1;
        @(posedge AXI_ACLK);
        #1;
        axi_read(A_IDX, rd);    check("rst_idx", rd, 32'd0);
        axi_read(A_WDATA, rd);  check("rst_wdata", rd, 32'd0);
        axi_read(A_RDATA, rd);  check("rst_rdata", rd, 32'd0);
        axi_read(A_STATUS, rd); check("rst_status", rd, 32'd0);

        // Directed table write
        wp0 = wr_pulses;
        axi_write(A_IDX, 32'd3);
        axi_write(A_WDATA, 32'h0A00_0001);
        axi_write(A_CMD, 32'd1);
        check("wr_req_latency", {31'b0, hs_wr_req}, 32'd1);
        model_mem[3] = 32'h0A00_0001;
        read_status_idle(st);
        check("wr_status", st, 32'h2);
        check("wr_pulse_cnt", wr_pulses - wp0, 32'd1);
        check("wr_addr", {27'b0, seen_wr_addr}, 32'd3);
        check("wr_data", seen_wr_data, 32'h0A00_0001);

        // Directed table read
        rp0 = rd_pulses;
        axi_write(A_CMD, 32'd2);
        check("rd_req_latency", {31'b0, hs_rd_req}, 32'd1);
        read_status_idle(st);
        check("rd_status", st, 32'h2);
        check("rd_pulse_cnt", rd_pulses - rp0, 32'd1);
        check("rd_addr", {27'b0, seen_rd_addr}, 32'd3);
        axi_read(A_RDATA, rd);
        check("rd_rdata", rd, 32'h0A00_0001);
        model_rdata = 32'h0A00_0001;

        // Malformed command and W1C
        wp0 = wr_pulses;
        rp0 = rd_pulses;
        axi_write(A_CMD, 32'd3);
        check("bad_cmd_noreq", {30'b0, hs_wr_req, hs_rd_req}, 32'd0);
        axi_read(A_STATUS, rd); check("bad_cmd_status", rd, 32'h6);
        axi_write(A_STATUS, 32'h4);
        axi_read(A_STATUS, rd); check("w1c_err", rd, 32'h2);
        axi_write(A_STATUS, 32'h2);
        axi_read(A_STATUS, rd); check("w1c_done", rd, 32'h0);
        axi_write(32'h14, 32'hFFFF_FFFF);
        axi_read(32'h14, rd);   check("unmapped_read", rd, 32'h0);
        check("bad_cmd_pulses", (wr_pulses - wp0) + (rd_pulses - rp0), 32'd0);

`ifdef DEST_IP_TBL_TIMEOUT_EN
        // Ack never returns: timeout after 16 wait cycles
        stall = 1'b1;
        axi_write(A_IDX, 32'd9);
        axi_write(A_CMD, 32'd2);
        repeat (30) @(posedge AXI_ACLK);
        #1;
        axi_read(A_STATUS, rd); check("tmo_status", rd, 32'hC);
        axi_read(A_RDATA, rd);  check("tmo_rdata_kept", rd, model_rdata);
        stall = 1'b0;
        axi_write(A_STATUS, 32'hE);
`else
        // Command while busy with a stalled ack
        stall = 1'b1;
        wp0 = wr_pulses;
        rp0 = rd_pulses;
        axi_write(A_IDX, 32'd7);
        axi_write(A_WDATA, 32'h1234_5678);
        axi_write(A_CMD, 32'd1);
        axi_read(A_STATUS, rd); check("busy_status", rd, 32'h1);
        axi_write(A_IDX, 32'd9);
        axi_write(A_WDATA, 32'hCAFE_F00D);
        axi_write(A_CMD, 32'd2);
        axi_read(A_STATUS, rd); check("busy_err_status", rd, 32'h5);
        check("busy_addr_stable", {27'b0, tbl_wr_addr}, 32'd7);
        check("busy_data_stable", tbl_wr_data, 32'h1234_5678);
        axi_read(A_IDX, rd);    check("busy_idx_updated", rd, 32'd9);
        force_wr_ack = 1'b1;
        @(posedge AXI_ACLK);
        @(posedge AXI_ACLK);
        #2;
        force_wr_ack = 1'b0;
        model_mem[7] = 32'h1234_5678;
        read_status_idle(st);
        check("busy_final_status", st, 32'h6);
        check("busy_one_pulse", (wr_pulses - wp0) + (rd_pulses - rp0), 32'd1);
        stall = 1'b0;
        axi_write(A_STATUS, 32'hE);
`endif

        // Randomized operations against the reference model
        for (int it = 0; it < 40; it++) begin
            idx = 5'($urandom_range(0, 31));
            wd  = $urandom;
            op  = $urandom_range(0, 3);
            wp0 = wr_pulses;
            rp0 = rd_pulses;
            axi_write(A_IDX, {27'b0, idx});
            axi_write(A_WDATA, wd);
            axi_write(A_CMD, 32'(op));
            read_status_idle(st);
            if (op == 1) begin
                model_mem[idx] = wd;
                check("rnd_wr_status", st, 32'h2);
                check("rnd_wr_pulses", wr_pulses - wp0, 32'd1);
                check("rnd_wr_addr", {27'b0, seen_wr_addr}, {27'b0, idx});
                check("rnd_wr_data", seen_wr_data, wd);
            end else if (op == 2) begin
                model_rdata = model_mem[idx];
                check("rnd_rd_status", st, 32'h2);
                check("rnd_rd_pulses", rd_pulses - rp0, 32'd1);
            end else begin
                check("rnd_bad_status", st, 32'h4);
                check("rnd_bad_pulses", (wr_pulses - wp0) + (rd_pulses - rp0), 32'd0);
            end
            axi_read(A_RDATA, rd);
            check("rnd_rdata", rd, model_rdata);
            axi_write(A_STATUS, 32'hE);
        end

        // Asynchronous reset while waiting on a read ack
        stall = 1'b1;
        axi_write(A_IDX, 32'd5);
        axi_write(A_CMD, 32'd2);
        check("pre_rst_rd_addr", {27'b0, tbl_rd_addr}, 32'd5);
        #2;
        AXI_RESETN = 1'b0;
        #1;
        check("async_rst_reqs", {30'b0, tbl_wr_req, tbl_rd_req}, 32'd0);
        check("async_rst_addrs", {22'b0, tbl_rd_addr, tbl_wr_addr}, 32'd0);
        repeat (2) @(posedge AXI_ACLK);
        stall = 1'b0;
        @(negedge AXI_ACLK);
        AXI_RESETN = 1'b1;
        model_rdata = 32'h0;
        axi_read(A_STATUS, rd); check("post_rst_status", rd, 32'h0);
        axi_read(A_RDATA, rd);  check("post_rst_rdata", rd, 32'h0);
        axi_write(A_CMD, 32'd2);
        read_status_idle(st);
        check("post_rst_rd_status", st, 32'h2);
        axi_read(A_RDATA, rd);  check("post_rst_rd_data", rd, model_mem[0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
